// File: rtl/tpu_pkg.sv
// rtl/tpu_pkg.sv - shared TPU datapath constants and weight-load state encoding
package tpu_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int PSUM_WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } wl_state_e;

endpackage

// File: rtl/pe_cell.sv
// rtl/pe_cell.sv - weight-stationary MAC cell: weight reg, ifmap pass-through reg, psum reg
//   w_load/w_in/w_out         : weight shift chain (column-wise, top to bottom)
//   ifmap_in/ifmap_out        : ifmap element moving left to right
//   psum_in/psum_out          : partial sum moving top to bottom
module pe_cell
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_load,
    input  logic [DATA_WIDTH-1:0] w_in,
    output logic [DATA_WIDTH-1:0] w_out,
    input  logic [DATA_WIDTH-1:0] ifmap_in,
    output logic [DATA_WIDTH-1:0] ifmap_out,
    input  logic [PSUM_WIDTH-1:0] psum_in,
    output logic [PSUM_WIDTH-1:0] psum_out
);

    logic signed [DATA_WIDTH-1:0]   w_s;
    logic signed [DATA_WIDTH-1:0]   x_s;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [PSUM_WIDTH-1:0]   prod_ext;

    assign w_s = w_out;
    assign x_s = ifmap_in;
    // Operands are sign-extended to the full product width first so the
    // multiply is exact regardless of context-width rules.
    assign prod     = (2*DATA_WIDTH)'(w_s) * (2*DATA_WIDTH)'(x_s);
    assign prod_ext = PSUM_WIDTH'(prod);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            w_out     <= '0;
            ifmap_out <= '0;
            psum_out  <= '0;
        end else begin
            if (w_load) begin
                w_out <= w_in;
            end
            ifmap_out <= ifmap_in;
            psum_out  <= psum_in + prod_ext;
        end
    end

endmodule

// File: rtl/systolic_array.sv
// rtl/systolic_array.sv - ROWSxCOLS weight-stationary systolic tile with skew/deskew and weight-load FSM
//   weight_i/weight_en_i      : weight row shifted into PE row 0 (accepted only when idle)
//   ifmap_i/psum_i/ifmap_en_i : aligned compute beat (accepted only when weights are READY)
//   psum_o/psum_en_o          : aligned result vector and its one-cycle valid pulse
//   weight_ready_o            : full weight tile loaded
//   busy_o                    : at least one accepted beat still in flight
module systolic_array
    import tpu_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int PSUM_WIDTH = PSUM_WIDTH_DEF,
    parameter int ROWS       = 4,
    parameter int COLS       = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [COLS*DATA_WIDTH-1:0] weight_i,
    input  logic                       weight_en_i,
    input  logic [ROWS*DATA_WIDTH-1:0] ifmap_i,
    input  logic [COLS*PSUM_WIDTH-1:0] psum_i,
    input  logic                       ifmap_en_i,
    output logic [COLS*PSUM_WIDTH-1:0] psum_o,
    output logic                       psum_en_o,
    output logic                       weight_ready_o,
    output logic                       busy_o
);

    localparam int LAT   = ROWS + COLS;
    localparam int CNT_W = $clog2(ROWS + 1);

    wl_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [LAT-1:0]   vld_q;
    logic             w_acc;
    logic             if_acc;

    // Loading has priority over compute; weights never move under a live beat.
    assign w_acc  = weight_en_i & ~busy_o;
    assign if_acc = ifmap_en_i & (state_q == READY) & ~w_acc;

    // ---------------- weight-load FSM ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (w_acc) begin
            if (state_q == READY) begin
                cnt_d   = CNT_W'(1);
                state_d = (ROWS == 1) ? READY : LOADING;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_d == CNT_W'(ROWS)) ? READY : LOADING;
            end
        end
    end

    always_comb begin
        weight_ready_o = (state_q == READY);
        busy_o         = |vld_q;
    end

    // ---------------- valid pipeline and output register ----------------
    logic [COLS*PSUM_WIDTH-1:0] psum_bot;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q     <= '0;
            psum_en_o <= 1'b0;
            psum_o    <= '0;
        end else begin
            vld_q     <= {vld_q[LAT-2:0], if_acc};
            psum_en_o <= vld_q[LAT-1];
            if (vld_q[LAT-1]) begin
                psum_o <= psum_bot;
            end
        end
    end

    // ---------------- PE array and interconnect ----------------
    logic [DATA_WIDTH-1:0] w_a   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] x_a   [ROWS][COLS];
    logic [PSUM_WIDTH-1:0] p_a   [ROWS][COLS];
    logic [DATA_WIDTH-1:0] row_in[ROWS];
    logic [PSUM_WIDTH-1:0] col_in[COLS];

    // Input skew lines are one stage deeper than the skew itself: stage 0
    // is the capture register for the accepted beat, which makes the total
    // path from acceptance to psum_o exactly ROWS+COLS edges.
    for (genvar r = 0; r < ROWS; r++) begin : g_row_skew
        logic [DATA_WIDTH-1:0] line [0:r];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i <= r; i++) line[i] <= '0;
            end else begin
                line[0] <= ifmap_i[r*DATA_WIDTH +: DATA_WIDTH];
                for (int i = 1; i <= r; i++) line[i] <= line[i-1];
            end
        end
        assign row_in[r] = line[r];
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col_skew
        logic [PSUM_WIDTH-1:0] line [0:c];
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                for (int i = 0; i <= c; i++) line[i] <= '0;
            end else begin
                line[0] <= psum_i[c*PSUM_WIDTH +: PSUM_WIDTH];
                for (int i = 1; i <= c; i++) line[i] <= line[i-1];
            end
        end
        assign col_in[c] = line[c];
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_pe_row
        for (genvar c = 0; c < COLS; c++) begin : g_pe_col
            logic [DATA_WIDTH-1:0] w_in;
            logic [DATA_WIDTH-1:0] x_in;
            logic [PSUM_WIDTH-1:0] p_in;

            if (r == 0) begin : g_top
                assign w_in = weight_i[c*DATA_WIDTH +: DATA_WIDTH];
                assign p_in = col_in[c];
            end else begin : g_inner_v
                assign w_in = w_a[r-1][c];
                assign p_in = p_a[r-1][c];
            end

            if (c == 0) begin : g_left
                assign x_in = row_in[r];
            end else begin : g_inner_h
                assign x_in = x_a[r][c-1];
            end

            pe_cell #(
                .DATA_WIDTH(DATA_WIDTH),
                .PSUM_WIDTH(PSUM_WIDTH)
            ) u_pe (
                .clk      (clk),
                .rst_n    (rst_n),
                .w_load   (w_acc),
                .w_in     (w_in),
                .w_out    (w_a[r][c]),
                .ifmap_in (x_in),
                .ifmap_out(x_a[r][c]),
                .psum_in  (p_in),
                .psum_out (p_a[r][c])
            );
        end
    end

    // ---------------- output deskew ----------------
    for (genvar c = 0; c < COLS; c++) begin : g_deskew
        localparam int D = COLS - 1 - c;
        if (D == 0) begin : g_direct
            assign psum_bot[c*PSUM_WIDTH +: PSUM_WIDTH] = p_a[ROWS-1][c];
        end else begin : g_delay
            logic [PSUM_WIDTH-1:0] line [0:D-1];
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) line[i] <= '0;
                end else begin
                    line[0] <= p_a[ROWS-1][c];
                    for (int i = 1; i < D; i++) line[i] <= line[i-1];
                end
            end
            assign psum_bot[c*PSUM_WIDTH +: PSUM_WIDTH] = line[D-1];
        end
    end

endmodule

// File: tb/tb_systolic_array.sv
// tb/tb_systolic_array.sv - randomized self-checking bench for systolic_array against a matrix-level model
module tb_systolic_array;

    localparam int DW   = 8;
    localparam int PW   = 32;
    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int LAT  = ROWS + COLS;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [COLS*DW-1:0]   weight_i;
    logic                 weight_en_i;
    logic [ROWS*DW-1:0]   ifmap_i;
    logic [COLS*PW-1:0]   psum_i;
    logic                 ifmap_en_i;
    logic [COLS*PW-1:0]   psum_o;
    logic                 psum_en_o;
    logic                 weight_ready_o;
    logic                 busy_o;

    systolic_array #(
        .DATA_WIDTH(DW),
        .PSUM_WIDTH(PW),
        .ROWS      (ROWS),
        .COLS      (COLS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .weight_i      (weight_i),
        .weight_en_i   (weight_en_i),
        .ifmap_i       (ifmap_i),
        .psum_i        (psum_i),
        .ifmap_en_i    (ifmap_en_i),
        .psum_o        (psum_o),
        .psum_en_o     (psum_en_o),
        .weight_ready_o(weight_ready_o),
        .busy_o        (busy_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference model: weight matrix, number of rows loaded, and a queue of
    // expected results tagged with the edge on which they must appear.
    typedef struct {
        int                 due;
        logic [COLS*PW-1:0] val;
    } exp_t;

    logic signed [DW-1:0] wm [ROWS][COLS];
    int                   rows_loaded;
    bit                   ready_m;
    exp_t                 pend[$];
    logic [COLS*PW-1:0]   last_out;
    int                   cyc;

    function automatic logic [COLS*PW-1:0] model_result(input logic [ROWS*DW-1:0] iv,
                                                        input logic [COLS*PW-1:0] pv);
        logic [COLS*PW-1:0]   res;
        logic signed [PW-1:0] s;
        for (int c = 0; c < COLS; c++) begin
            s = pv[c*PW +: PW];
            for (int r = 0; r < ROWS; r++)
                s = s + PW'(wm[r][c]) * PW'($signed(iv[r*DW +: DW]));
            res[c*PW +: PW] = s;
        end
        return res;
    endfunction

    task automatic cycle(input bit rst, input bit wen, input logic [COLS*DW-1:0] wv,
                         input bit ien, input logic [ROWS*DW-1:0] iv, input logic [COLS*PW-1:0] pv);
        bit   busy_m, w_acc, i_acc;
        exp_t e;
        rst_n       = ~rst;
        weight_en_i = wen;
        weight_i    = wv;
        ifmap_en_i  = ien;
        ifmap_i     = iv;
        psum_i      = pv;

        busy_m = (pend.size() != 0);
        w_acc  = !rst && wen && !busy_m;
        i_acc  = !rst && ien && ready_m && !w_acc;
        if (rst) begin
            pend.delete();
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++) wm[r][c] = '0;
            rows_loaded = 0;
            ready_m     = 0;
            last_out    = '0;
        end else begin
            if (i_acc) begin
                e.due = cyc + 1 + LAT;
                e.val = model_result(iv, pv);
                pend.push_back(e);
            end
            if (w_acc) begin
                for (int r = ROWS - 1; r > 0; r--) wm[r] = wm[r-1];
                for (int c = 0; c < COLS; c++) wm[0][c] = wv[c*DW +: DW];
                rows_loaded = ready_m ? 1 : rows_loaded + 1;
                ready_m     = (rows_loaded == ROWS);
            end
        end

        @(posedge clk);
        cyc++;
        #1;
        if (pend.size() != 0 && pend[0].due == cyc) begin
            last_out = pend[0].val;
            void'(pend.pop_front());
            check("psum_en_o", psum_en_o, 1'b1);
        end else begin
            check("psum_en_o", psum_en_o, 1'b0);
        end
        check("psum_o", psum_o, last_out);
        check("busy_o", busy_o, pend.size() != 0);
        check("weight_ready_o", weight_ready_o, ready_m);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 0, '0, 0, '0, '0);
    endtask

    task automatic load(input logic [COLS*DW-1:0] wv);
        cycle(0, 1, wv, 0, '0, '0);
    endtask

    task automatic beat(input logic [ROWS*DW-1:0] iv, input logic [COLS*PW-1:0] pv);
        cycle(0, 0, '0, 1, iv, pv);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        cyc = 0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++) wm[r][c] = '0;
        rows_loaded = 0;
        ready_m     = 0;
        last_out    = '0;

        // Reset state.
        cycle(1, 0, '0, 0, '0, '0);
        cycle(1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, '1);
        idle(2);

        // Identity load (bottom row first) and a single beat.
        for (int j = 0; j < ROWS; j++) load(32'd1 << ((ROWS - 1 - j) * DW));
        beat({8'd4, 8'd3, 8'd2, 8'd1}, '0);
        idle(LAT + 1);
        check("identity_result", psum_o, {32'd4, 32'd3, 32'd2, 32'd1});

        // Signed extremes.
        for (int j = 0; j < ROWS; j++) load({4{8'h80}});
        beat({4{8'h7F}}, {4{32'd1000}});
        idle(LAT + 1);
        check("extreme_result", psum_o, {4{32'(-64024)}});

        // Streaming: 6 back-to-back, 2-cycle bubble, 2 more.
        for (int j = 0; j < 6; j++) beat($urandom, rnd128());
        idle(2);
        for (int j = 0; j < 2; j++) beat($urandom, rnd128());
        idle(LAT + 2);

        // Illegal timing: beats in EMPTY and LOADING, load while busy,
        // simultaneous load and beat in idle READY.
        cycle(1, 0, '0, 0, '0, '0);
        beat($urandom, rnd128());
        load($urandom);
        load($urandom);
        beat($urandom, rnd128());
        load($urandom);
        load($urandom);
        beat($urandom, rnd128());
        cycle(0, 1, $urandom, 1, $urandom, rnd128());
        beat($urandom, rnd128());
        idle(LAT + 1);
        cycle(0, 1, $urandom, 1, $urandom, rnd128());
        check("simul_load_not_ready", weight_ready_o, 1'b0);

        // Reload: finish the restarted load, new weights show up in results.
        for (int j = 0; j < ROWS - 1; j++) load($urandom);
        beat($urandom, rnd128());
        idle(LAT + 1);

        // Reset while three beats are in flight.
        for (int j = 0; j < 3; j++) beat($urandom, rnd128());
        cycle(1, 0, '0, 0, '0, '0);
        check("mid_reset_psum_o", psum_o, '0);
        idle(LAT + 2);

        // Randomized blocks: fresh random weights, then random traffic with
        // occasional load attempts that may land while busy or idle.
        for (int b = 0; b < 8; b++) begin
            idle(LAT + 1);
            for (int j = 0; j < ROWS; j++) load($urandom);
            for (int j = 0; j < 30; j++)
                cycle(0, $urandom_range(0, 11) == 0, $urandom,
                      $urandom_range(0, 2) != 0, $urandom, rnd128());
        end
        idle(LAT + 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_array.md
# systolic_array

Parametrised weight-stationary systolic array of ROWS×COLS processing elements (PEs) for the TPU datapath.
- Generalises the single PE into a full tile with internal input/psum skew and output deskew, so callers drive and receive aligned vectors.
- Includes a weight-load state machine and a per-beat valid pipeline.
- Sits between the ifmap/weight buffers and the accumulator stage.

## Interface
- DATA_WIDTH, 8, signed weight/ifmap element width
- PSUM_WIDTH, 32, signed partial-sum width; must be ≥ 2*DATA_WIDTH
- ROWS, 4, PE rows (≥1); one ifmap element per row
- COLS, 4, PE columns (≥1); one psum per column

Clock and reset:
- One clock; reset is synchronous and active-low.
- clk  in  1  clock; all registers update on the rising edge
- rst_n  in  1  synchronous active-low reset

Weight load:
- weight_i  in  COLS*DATA_WIDTH  weight row; element c in bits [c*DATA_WIDTH +: DATA_WIDTH]
- weight_en_i  in  1  shift weight_i into PE row 0

Compute:
- ifmap_i  in  ROWS*DATA_WIDTH  ifmap vector; element r feeds row r
- psum_i  in  COLS*PSUM_WIDTH  top-of-column psum bias, sampled with ifmap_i
- ifmap_en_i  in  1  ifmap_i/psum_i beat valid

Outputs:
- psum_o  in the output direction  COLS*PSUM_WIDTH  aligned result vector
- psum_en_o  out  1  psum_o valid, one-cycle pulse per beat
- weight_ready_o  out  1  full weight tile loaded
- busy_o  out  1  at least one accepted beat still in flight

## Operation
Weight load FSM (states EMPTY, LOADING, READY):
- Reset → EMPTY with cnt=0.
- Accepted weight_en_i does two things:
  - shifts weights down: w(0,c)←weight_i[c], w(r,c)←w(r-1,c);
  - cnt←cnt+1, going to LOADING, or to READY when cnt reaches ROWS.
- Row-fill order: the first accepted beat ends in row ROWS-1.
- Gaps between load beats are allowed.
- weight_en_i is accepted only while busy_o=0. While busy_o=1 it is ignored: no shift, no state change.
- An accepted weight_en_i in READY restarts loading: state→LOADING (READY if ROWS=1), cnt=1.
- weight_ready_o = (state==READY).

Compute path:
- ifmap_en_i is accepted only when state==READY and weight_en_i is not accepted in the same cycle (load has priority). A rejected beat is dropped silently.
- Input skew: ifmap row r is delayed r cycles; psum_i column c is delayed c cycles.
- PE(r,c) registers:
  - ifmap_q ← ifmap_in;
  - psum_q ← psum_in + sext(w(r,c) × ifmap_in).
- ifmap_in comes from the left neighbour (or the skew line); psum_in comes from the PE above (or the psum_i skew line).
- Arithmetic is signed DATA_WIDTH×DATA_WIDTH → 2*DATA_WIDTH, sign-extended to PSUM_WIDTH, with the sum wrapping modulo 2^PSUM_WIDTH. No saturation.
- Output deskew: column c bottom psum is delayed COLS-1-c cycles, then goes through a common output register.
- Result: psum_o[c] = psum_i[c] + Σr w(r,c)·ifmap_i[r] for each accepted beat.
- A valid bit travels in a shift register of length L and drives psum_en_o.
- psum_o loads only when the valid bit arrives and holds its value otherwise.
- busy_o = OR of all valid-pipeline bits.

## Timing
- Latency L = ROWS+COLS (8 for 4×4): a beat accepted at edge k gives psum_en_o=1 and psum_o valid during the cycle after edge k+L.
- Throughput is one beat per cycle; back-to-back and bubbled beats are both supported, and results come out in order.
- Reset values:
  - psum_o=0, psum_en_o=0, weight_ready_o=0, busy_o=0;
  - all weights, skew/deskew registers, PE registers and valid bits = 0;
  - FSM = EMPTY.
- Reset mid-operation drops all in-flight beats; no psum_en_o pulse follows.
- weight_en_i and ifmap_en_i in the same cycle while busy_o=0 and in READY: the load is taken, the ifmap beat is dropped.
- After the last beat leaves, busy_o falls in the same cycle that beat's psum_en_o rises. From that cycle on, weight_en_i is accepted.

## Structure
- Shared package tpu_pkg holds:
  - default DATA_WIDTH/PSUM_WIDTH constants;
  - the FSM state enum {EMPTY, LOADING, READY}.
- Sub-module pe_cell holds the weight register, ifmap_q, psum_q and the MAC. It is instantiated ROWS×COLS times in a generate loop.
- Skew lines, deskew lines, the FSM and the valid pipeline live in systolic_array.

## Test plan
1. Reset then identity load: rows loaded bottom-first as e3, e2, e1, e0. Then beat ifmap=[1,2,3,4], psum_i=0 → weight_ready_o=1 after the 4th beat, psum_o=[1,2,3,4], psum_en_o exactly 8 cycles after acceptance.
2. Signed/extremes: all weights −128, ifmap all 127, psum_i[c]=1000 → each psum_o = 1000 − 4·16256 = −64024.
3. Streaming: 6 back-to-back beats, then a 2-cycle bubble, then 2 beats → 8 in-order results. psum_en_o mirrors the input valid pattern delayed 8 cycles. busy_o drops with the last result.
4. Illegal timing:
   - ifmap_en_i in EMPTY/LOADING is dropped.
   - weight_en_i while busy_o=1 is ignored: weights unchanged, results still correct.
   - A simultaneous weight_en_i/ifmap_en_i in idle READY loads and drops the beat.
5. Reload: in READY and idle, one weight_en_i → weight_ready_o=0, cnt=1. Three more beats → READY, and new weights are reflected in the next result.
6. Reset mid-stream: rst_n=0 for one cycle while 3 beats are in flight → all outputs 0, no psum_en_o pulse, FSM=EMPTY.
